down_timer: RTL and testbench

//  Loadable down-counting timer: complements the loadable up-counter in this design.

---
 rtl/down_timer.sv | 90 +++++++++
 tb/tb_down_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes, a one-cycle
// terminal-count pulse, a saturating expiry counter and an output-enabled count bus.
module down_timer #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    input  logic             oe,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic [EXP_W-1:0] exp_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   reload_q, reload_d;
    logic               tc_q, tc_d;
    logic [EXP_W-1:0]   exp_q, exp_d;

    // Expiry counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [EXP_W-1:0] sat_inc(input logic [EXP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            exp_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            exp_q    <= exp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        exp_d    = exp_q;
        if (load) begin
            // Load wins over en; a zero start value has nothing to count.
            count_d  = load_val;
            reload_d = load_val;
            exp_d    = '0;
            state_d  = (load_val != '0) ? S_RUN : S_IDLE;
        end else if (state_q == S_RUN && en) begin
            if (count_q == ONE) begin
                tc_d  = 1'b1;
                exp_d = sat_inc(exp_q);
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = S_DONE;
                end
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    assign count_out = oe ? count_q : '0;
    assign tc        = tc_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign exp_cnt   = exp_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: a behavioural reference checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_down_timer;

    localparam int WIDTH   = 8;
    localparam int EXP_W   = 4;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic             en = 1'b0;
    logic             auto_reload = 1'b0;
    logic             oe = 1'b0;
    logic [WIDTH-1:0] count_out;
    logic             tc;
    logic             busy;
    logic             done;
    logic [EXP_W-1:0] exp_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // Reference state: plain integers, mode as a small number.
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    int m_count = 0, m_reload = 0, m_exp = 0, m_mode = M_IDLE;
    bit m_tc = 1'b0;

    down_timer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
        .auto_reload(auto_reload), .oe(oe), .count_out(count_out), .tc(tc),
        .busy(busy), .done(done), .exp_cnt(exp_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            m_count <= 0; m_reload <= 0; m_exp <= 0; m_tc <= 1'b0; m_mode <= M_IDLE;
        end else if (load) begin
            m_count  <= int'(load_val);
            m_reload <= int'(load_val);
            m_exp    <= 0;
            m_tc     <= 1'b0;
            m_mode   <= (load_val != 0) ? M_RUN : M_IDLE;
        end else if (m_mode == M_RUN && en) begin
            if (m_count == 1) begin
                m_tc  <= 1'b1;
                m_exp <= (m_exp + 1 > EXP_MAX) ? EXP_MAX : m_exp + 1;
                if (auto_reload) m_count <= m_reload;
                else begin
                    m_count <= 0;
                    m_mode  <= M_DONE;
                end
            end else begin
                m_count <= m_count - 1;
                m_tc    <= 1'b0;
            end
        end else begin
            m_tc <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cmp_count_out", int'(count_out), oe ? m_count : 0);
            chk("cmp_tc", int'(tc), int'(m_tc));
            chk("cmp_busy", int'(busy), int'(m_mode == M_RUN));
            chk("cmp_done", int'(done), int'(m_mode == M_DONE));
            chk("cmp_exp_cnt", int'(exp_cnt), m_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string name, input int c, input int t,
                              input int b, input int d, input int e);
        chk({name, "_count"}, int'(count_out), c);
        chk({name, "_tc"}, int'(tc), t);
        chk({name, "_busy"}, int'(busy), b);
        chk({name, "_done"}, int'(done), d);
        chk({name, "_exp"}, int'(exp_cnt), e);
    endtask

    initial begin
        int seq3[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        int pulses;

        // Reset held two cycles while other inputs toggle
        rst = 1'b1; load = 1'b1; load_val = 8'hAA; en = 1'b1; auto_reload = 1'b1; oe = 1'b1;
        tick();
        cmp_on = 1'b1;
        expect_all("rst1", 0, 0, 0, 0, 0);
        load = 1'b0; en = 1'b0; auto_reload = 1'b0; load_val = 8'h55;
        tick();
        expect_all("rst2", 0, 0, 0, 0, 0);

        // en in IDLE must not wrap the count
        rst = 1'b0; en = 1'b1; oe = 1'b1;
        tick();
        expect_all("idle_en", 0, 0, 0, 0, 0);

        // One-shot from 5
        load = 1'b1; load_val = 8'd5; en = 1'b1; auto_reload = 1'b0;
        tick();
        expect_all("os_load", 5, 0, 1, 0, 0);
        load = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            tick();
            chk("os_count", int'(count_out), i);
        end
        tick();
        expect_all("os_expire", 0, 1, 0, 1, 1);
        tick();
        expect_all("os_hold", 0, 0, 0, 1, 1);

        // Auto-reload from 3, nine enabled cycles
        load = 1'b1; load_val = 8'd3; auto_reload = 1'b1;
        tick();
        expect_all("ar_load", 3, 0, 1, 0, 0);
        load = 1'b0;
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("ar_count", int'(count_out), seq3[i]);
            chk("ar_busy", int'(busy), 1);
            if (tc) pulses++;
        end
        chk("ar_pulses", pulses, 3);
        chk("ar_exp", int'(exp_cnt), 3);

        // Reload value 1: tc every cycle, expiry counter saturates
        load = 1'b1; load_val = 8'd1;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("sat_tc", int'(tc), 1);
            chk("sat_exp", int'(exp_cnt), (i > 15) ? 15 : i);
        end
        expect_all("sat_end", 1, 1, 1, 0, 15);

        // Load beats en at count 1, then load of zero
        load = 1'b1; load_val = 8'd1; auto_reload = 1'b0;
        tick();
        load_val = 8'd7; en = 1'b1;
        tick();
        expect_all("ld_pri", 7, 0, 1, 0, 0);
        load_val = 8'd0;
        tick();
        expect_all("ld_zero", 0, 0, 0, 0, 0);

        // Output enable gating mid-run, pause, then reset abort
        load_val = 8'd9;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("oe_mid", int'(count_out), 4);
        oe = 1'b0;
        tick();
        chk("oe_off1", int'(count_out), 0);
        tick();
        chk("oe_off2", int'(count_out), 0);
        oe = 1'b1; en = 1'b0;
        tick();
        expect_all("oe_pause", 2, 0, 1, 0, 0);
        en = 1'b1; rst = 1'b1;
        tick();
        expect_all("rst_mid", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        expect_all("rst_after", 0, 0, 0, 0, 0);

        @(negedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
